// File: rtl/ram_arb_pkg.sv
// Shared widths and port indices for the RAM4K two-port arbiter.
package ram_arb_pkg;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int WAIT_W   = 4;
  localparam int PORT_CPU = 0;
  localparam int PORT_AUX = 1;
endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of consecutive cycles port 1 has been denied, and the
// override flag raised once that count reaches MAX_WAIT.
module ram_arb_starve_ctr
  import ram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic gnt1,
  output logic override
);

  localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req1 || gnt1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_C) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign override = req1 && (wait_cnt_q == MAX_C);

endmodule

// File: rtl/ram4k_arbiter.sv
// Fixed-priority two-port arbiter in front of one external RAM4K bank.
// Define RAM4K_ARB_STARVE_GUARD_EN to bound port 1's wait to MAX_WAIT cycles.
module ram4k_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  logic override;

`ifdef RAM4K_ARB_STARVE_GUARD_EN
  ram_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .req1     (req1),
    .gnt1     (gnt1),
    .override (override)
  );
`else
  // Without the guard MAX_WAIT has no effect; it is tied off here.
  logic unused_max_wait;
  assign unused_max_wait = ^(WAIT_W'(MAX_WAIT));
  assign override        = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (override) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Idle cycles park the RAM on port 0's address with load low.
  assign ram_address = gnt1 ? addr1  : addr0;
  assign ram_in      = gnt1 ? wdata1 : wdata0;
  assign ram_load    = (gnt0 & we0) | (gnt1 & we1);

  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q,  rdata0_d;
  logic [DATA_W-1:0] rdata1_q,  rdata1_d;

  always_comb begin
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? ram_out : rdata0_q;
    rdata1_d  = rvalid1_d ? ram_out : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Directed bench for ram4k_arbiter with a behavioural RAM4K model attached.
module tb_ram4k_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [11:0] ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  logic [15:0] mem [4096];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram4k_arbiter #(
    .MAX_WAIT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out)
  );

  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end
  assign ram_out = mem[ram_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    // Reset held two cycles with both ports requesting writes
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h0A5; wdata0 = 16'hDEAD;
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h010; wdata1 = 16'hCAFE;
    tick();
    for (int c = 0; c < 2; c++) begin
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_gnt1", gnt1, 1'b0);
      check("rst_load", ram_load, 1'b0);
      check("rst_rvalid0", rvalid0, 1'b0);
      check("rst_rvalid1", rvalid1, 1'b0);
      check("rst_rdata0", rdata0, 16'h0000);
      check("rst_rdata1", rdata1, 16'h0000);
      tick();
    end
    check("rst_mem_0a5", mem[12'h0A5], 16'h0000);
    check("rst_mem_010", mem[12'h010], 16'h0000);

    // Idle: address/data follow port 0, no load
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b1; we1 = 1'b1;
    addr0 = 12'h123; addr1 = 12'h456; wdata0 = 16'h1111; wdata1 = 16'h2222;
    #1;
    check("idle_gnt0", gnt0, 1'b0);
    check("idle_gnt1", gnt1, 1'b0);
    check("idle_addr", ram_address, 12'h123);
    check("idle_in", ram_in, 16'h1111);
    check("idle_load", ram_load, 1'b0);
    tick();
    check("idle_mem", mem[12'h123], 16'h0000);

    // Port 0 write 0x1234 @ 0x0A5 then read it back next cycle
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h0A5; wdata0 = 16'h1234;
    #1;
    check("p0w_gnt0", gnt0, 1'b1);
    check("p0w_load", ram_load, 1'b1);
    check("p0w_addr", ram_address, 12'h0A5);
    tick();
    check("p0w_rvalid0", rvalid0, 1'b0);
    we0 = 1'b0;
    #1;
    check("p0r_gnt0", gnt0, 1'b1);
    check("p0r_load", ram_load, 1'b0);
    tick();
    check("p0r_rvalid0", rvalid0, 1'b1);
    check("p0r_rdata0", rdata0, 16'h1234);
    req0 = 1'b0;
    tick();
    check("p0r_rvalid0_drop", rvalid0, 1'b0);
    check("p0r_rdata0_hold", rdata0, 16'h1234);

    // Port 1 writes 0xBEEF @ 0xFFF; port 0 reads it the following cycle
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'hFFF; wdata1 = 16'hBEEF;
    #1;
    check("p1w_gnt1", gnt1, 1'b1);
    check("p1w_gnt0", gnt0, 1'b0);
    check("p1w_load", ram_load, 1'b1);
    check("p1w_addr", ram_address, 12'hFFF);
    check("p1w_in", ram_in, 16'hBEEF);
    tick();
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'hFFF;
    #1;
    check("xr_gnt0", gnt0, 1'b1);
    tick();
    check("xr_rvalid0", rvalid0, 1'b1);
    check("xr_rdata0", rdata0, 16'hBEEF);
    check("xr_rvalid1", rvalid1, 1'b0);

    // Port 1 read of the same word
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'hFFF;
    #1;
    check("p1r_gnt1", gnt1, 1'b1);
    tick();
    check("p1r_rvalid1", rvalid1, 1'b1);
    check("p1r_rdata1", rdata1, 16'hBEEF);
    req1 = 1'b0;
    tick();

    // Contention: both ports read continuously for 15 cycles
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0A5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'hFFF;
    for (int c = 1; c <= 15; c++) begin
`ifdef RAM4K_ARB_STARVE_GUARD_EN
      automatic logic exp1 = (c % 5 == 0);
`else
      automatic logic exp1 = 1'b0;
`endif
      #1;
      check($sformatf("cont_gnt1_c%0d", c), gnt1, exp1);
      check($sformatf("cont_gnt0_c%0d", c), gnt0, !exp1);
      tick();
      check($sformatf("cont_rvalid1_c%0d", c), rvalid1, exp1);
      check($sformatf("cont_rvalid0_c%0d", c), rvalid0, !exp1);
      if (exp1) check($sformatf("cont_rdata1_c%0d", c), rdata1, 16'hBEEF);
      else      check($sformatf("cont_rdata0_c%0d", c), rdata0, 16'h1234);
    end

`ifdef RAM4K_ARB_STARVE_GUARD_EN
    // Withdrawal: 3 denied cycles, drop one cycle, then 4 more denied before override
    req1 = 1'b0;
    tick();
    req1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("wd_pre_gnt1_c%0d", c), gnt1, 1'b0);
      tick();
    end
    req1 = 1'b0;
    tick();
    req1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("wd_post_gnt1_c%0d", c), gnt1, 1'b0);
      check($sformatf("wd_post_gnt0_c%0d", c), gnt0, 1'b1);
      tick();
    end
    #1;
    check("wd_override_gnt1", gnt1, 1'b1);
    check("wd_override_gnt0", gnt0, 1'b0);
    tick();
    check("wd_override_rvalid1", rvalid1, 1'b1);
`endif

    // Reset rising in a read-grant cycle suppresses the response; a write is dropped
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0A5;
    tick();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0A5; wdata1 = 16'h5555;
    #1;
    check("rstw_gnt1", gnt1, 1'b0);
    check("rstw_load", ram_load, 1'b0);
    tick();
    check("rstw_rvalid0", rvalid0, 1'b0);
    check("rstw_rdata0", rdata0, 16'h0000);
    check("rstw_mem", mem[12'h0A5], 16'h1234);
    reset = 1'b0;
    req1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram4k_arbiter.md
# ram4k_arbiter

Two-port arbiter that shares one 4K x 16 RAM bank (RAM4K) between two requesters: the Hack CPU data port (port 0) and a secondary master such as the video scanout or ROM/RAM loader (port 1). Each cycle it grants at most one access, drives the RAM's `address`/`in`/`load` from the winner, and registers read data back to that requester one cycle later. Port 0 has fixed priority. An optional starvation guard bounds port 1's wait time.

## Interface
Parameters:
- `MAX_WAIT`, default 4: consecutive denied cycles after which port 1 overrides port 0. Only used with the guard enabled. Legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: access request, port 0 / port 1.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in 12: word address.
- `wdata0` / `wdata1` in 16: write data.
- `gnt0` / `gnt1` out 1: combinational grant, same cycle as the request.
- `rvalid0` / `rvalid1` out 1: read data valid, one cycle after a read grant.
- `rdata0` / `rdata1` out 16: registered read data.
- `ram_address` out 12: to RAM `address`.
- `ram_in` out 16: to RAM `in`.
- `ram_load` out 1: to RAM `load`.
- `ram_out` in 16: from RAM `out`. Combinational read of `ram_address`.

## Operation
- Handshake: a requester holds `req`/`we`/`addr`/`wdata` stable until it sees `gnt` high in that cycle. The transfer completes on the edge that ends the grant cycle. A requester may drop `req` before grant; nothing happens.
- Grant function, in priority order:
  1. While `reset` is high: `gnt0` = `gnt1` = 0.
  2. Guard override: `req1` and `wait_cnt == MAX_WAIT` → `gnt1`.
  3. Otherwise `req0` → `gnt0`.
  4. Otherwise `req1` → `gnt1`.
- At most one grant is high in any cycle.
- Mux: `ram_address`/`ram_in` follow the granted port. With no grant they follow port 0 and `ram_load` is 0.
- `ram_load` = (`gnt0` & `we0`) | (`gnt1` & `we1`). The write lands on the edge ending the grant cycle.
- Read: on the edge ending a read grant for port n, `rdata_n` ← `ram_out` and `rvalid_n` ← 1. Otherwise `rvalid_n` ← 0 and `rdata_n` holds its value.
- Writes produce no response; `gnt` is the completion.
- `wait_cnt` (4 bits):
  - cleared when `req1` is low or `gnt1` is high;
  - otherwise incremented, saturating at `MAX_WAIT`.

## Timing
- Grant latency: 0 cycles, combinational from `req*` and `wait_cnt`.
- Read latency: data valid 1 cycle after the grant cycle. Back-to-back reads from one port give one result per cycle.
- Read-after-write to the same address in the next cycle, from either port, returns the new data.
- Port 1 worst-case wait under continuous port 0 traffic: `MAX_WAIT` cycles, with the guard enabled. After an override grant, `wait_cnt` is 0, so port 0 wins the next cycle.
- Reset values: `rvalid0`/`rvalid1` = 0, `rdata0`/`rdata1` = 0, `wait_cnt` = 0, `ram_load` = 0, grants = 0.
- Reset asserted mid-read: the pending `rvalid` is suppressed. A write granted in the same cycle `reset` rises is dropped, because `ram_load` is forced to 0.

## Configuration
- `RAM4K_ARB_STARVE_GUARD_EN` defined:
  - `wait_cnt` and the override rule are built;
  - `MAX_WAIT` is honoured.
- Not defined:
  - pure fixed priority, port 0 always wins;
  - no counter state;
  - port 1 can starve indefinitely;
  - `MAX_WAIT` is ignored.

## Structure
- Shared package `ram_arb_pkg` holds:
  - `ADDR_W` = 12 and `DATA_W` = 16;
  - `WAIT_W` = 4;
  - port index constants `PORT_CPU` = 0 and `PORT_AUX` = 1.
- Sub-module `ram_arb_starve_ctr` holds the saturating wait counter and the override compare, instantiated only under the macro.
- The RAM itself is external; the arbiter contains no storage beyond the read-data registers.

## Test plan
- Reset: hold `reset` 2 cycles with `req0` = `req1` = 1, `we0` = 1 → no grants, `ram_load` 0, `rvalid*`/`rdata*` = 0, RAM unchanged.
- Single port write then read:
  - port 0 writes 0x1234 at 0x0A5, then reads 0x0A5 next cycle;
  - required: `gnt0` both cycles, `rvalid0` = 1 with `rdata0` = 0x1234 one cycle after the read grant.
- Contention without guard (macro off): both ports request reads for 10 cycles → `gnt0` every cycle, `gnt1` never.
- Starvation guard (macro on, `MAX_WAIT` = 4):
  - `req0` and `req1` held high continuously;
  - required: `gnt1` on cycles 5, 10, 15, …;
  - `rvalid1` one cycle after each of those grants;
  - `gnt0` on all other cycles.
- Cross-port coherence:
  - port 1 writes 0xBEEF at 0xFFF;
  - port 0 reads 0xFFF in the following cycle;
  - required: `rdata0` = 0xBEEF. Address 0xFFF also exercises the top bank select.
- Request withdrawal (macro on):
  - `req1` high 3 denied cycles, dropped 1 cycle, re-raised;
  - required: `wait_cnt` restarts at 0, so the override is not reached until 4 further denied cycles.
